// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 scan reader.
// Holds the FSM state enum, plane count, word bit offsets and a bit-plane helper.
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    DATA,
    CLKH,
    LATCH,
    BLANK,
    DISPLAY
  } scan_state_t;

  localparam int BPP_DEF = 12;
  localparam int PLANES  = BPP_DEF / 3;

  localparam int R_TOP = 20;
  localparam int G_TOP = 16;
  localparam int B_TOP = 12;
  localparam int R_BOT = 8;
  localparam int G_BOT = 4;
  localparam int B_BOT = 0;

  // Bit p of the 4-bit colour channel starting at bit 'off' of a word.
  function automatic logic plane_bit(
    input logic [23:0] w,
    input int          off,
    input logic [1:0]  p
  );
    logic [3:0] nib;
    nib = w[off +: 4];
    return nib[p];
  endfunction

endpackage

// File: rtl/bcm_timer.sv
// Load-and-count-down timer for BCM display and blank intervals.
// Ports: clk, rst, load, value (W bits), done (high in the last counted cycle).
module bcm_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Loaded with N, done is seen in the Nth cycle after the load.
  assign done = (cnt == W'(1));

endmodule

// File: rtl/hub75_scan_reader.sv
// HUB75 BCM scan engine: reads framebuffer words and drives the panel pins.
// Ports: clk, rst, enable, mem_addr/mem_re/mem_dat, panel_* pins, frame_done.
// Build option SCAN_BLANK_EN adds a blank guard between LATCH and DISPLAY.
module hub75_scan_reader
  import hub75_pkg::*;
#(
  parameter int WIDTH          = 96,
  parameter int HEIGHT         = 48,
  parameter int BPP            = 12,
  parameter int CHAINED        = 1,
  parameter int ADDR_W         = 12,
  parameter int ROW_W          = 5,
  parameter int BASE_OE_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [23:0]       mem_dat,
  output logic              panel_r0,
  output logic              panel_g0,
  output logic              panel_b0,
  output logic              panel_r1,
  output logic              panel_g1,
  output logic              panel_b1,
  output logic [ROW_W-1:0]  panel_addr,
  output logic              panel_clk,
  output logic              panel_lat,
  output logic              panel_oe_n,
  output logic              frame_done
);

  localparam int LINE = CHAINED * WIDTH;
  localparam int ROWS = HEIGHT / 2;
  localparam int PL   = BPP / 3;
  localparam int CW   = (LINE > 1) ? $clog2(LINE) : 1;
  localparam int PW   = $clog2(PLANES);
  localparam int MAXT = BASE_OE_CYCLES << (PL - 1);
  localparam int TW   = $clog2(MAXT + 1) + 1;

  scan_state_t    state;
  logic [ROW_W-1:0] row;
  logic [CW-1:0]    col;
  logic [PW-1:0]    plane;

  logic           t_load;
  logic           t_done;
  logic [TW-1:0]  t_val;
  logic [TW-1:0]  oe_len;

  assign oe_len = TW'(BASE_OE_CYCLES) << plane;

`ifdef SCAN_BLANK_EN
  localparam int BLANK_CYCLES = 4;

  // One timer serves both intervals: blank first, display reloaded after.
  assign t_load = (state == LATCH)
               || ((state == BLANK) && t_done);
  assign t_val  = (state == LATCH) ? TW'(BLANK_CYCLES)
                                   : oe_len;
`else
  assign t_load = (state == LATCH);
  assign t_val  = oe_len;
`endif

  bcm_timer #(
    .W(TW)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (t_load),
    .value(t_val),
    .done (t_done)
  );

  function automatic logic [ADDR_W-1:0] addr_of(
    input logic [ROW_W-1:0] r,
    input logic [CW-1:0]    c
  );
    return ADDR_W'(r) * ADDR_W'(LINE) + ADDR_W'(c);
  endfunction

  logic last_col;
  logic last_row;
  logic last_pl;

  assign last_col = (col == CW'(LINE - 1));
  assign last_row = (row == ROW_W'(ROWS - 1));
  assign last_pl  = (plane == PW'(PL - 1));

  // Outputs are registered: each transition sets the values for the
  // state being entered, so they line up with that state's cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      plane      <= '0;
      mem_addr   <= '0;
      mem_re     <= 1'b0;
      panel_r0   <= 1'b0;
      panel_g0   <= 1'b0;
      panel_b0   <= 1'b0;
      panel_r1   <= 1'b0;
      panel_g1   <= 1'b0;
      panel_b1   <= 1'b0;
      panel_addr <= '0;
      panel_clk  <= 1'b0;
      panel_lat  <= 1'b0;
      panel_oe_n <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      mem_re     <= 1'b0;
      panel_clk  <= 1'b0;
      panel_lat  <= 1'b0;
      panel_oe_n <= 1'b1;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            row      <= '0;
            col      <= '0;
            plane    <= '0;
            mem_addr <= '0;
            mem_re   <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          state <= DATA;
        end
        DATA: begin
          panel_r0  <= plane_bit(mem_dat, R_TOP, plane);
          panel_g0  <= plane_bit(mem_dat, G_TOP, plane);
          panel_b0  <= plane_bit(mem_dat, B_TOP, plane);
          panel_r1  <= plane_bit(mem_dat, R_BOT, plane);
          panel_g1  <= plane_bit(mem_dat, G_BOT, plane);
          panel_b1  <= plane_bit(mem_dat, B_BOT, plane);
          panel_clk <= 1'b1;
          state     <= CLKH;
        end
        CLKH: begin
          if (!last_col) begin
            col      <= col + 1'b1;
            mem_addr <= addr_of(row, col + 1'b1);
            mem_re   <= 1'b1;
            state    <= REQ;
          end else begin
            col        <= '0;
            panel_lat  <= 1'b1;
            panel_addr <= row;
            state      <= LATCH;
          end
        end
        LATCH: begin
`ifdef SCAN_BLANK_EN
          state <= BLANK;
`else
          panel_oe_n <= 1'b0;
          state      <= DISPLAY;
`endif
        end
`ifdef SCAN_BLANK_EN
        BLANK: begin
          if (t_done) begin
            panel_oe_n <= 1'b0;
            state      <= DISPLAY;
          end
        end
`endif
        DISPLAY: begin
          if (!t_done) begin
            panel_oe_n <= 1'b0;
          end else if (!last_pl) begin
            plane    <= plane + 1'b1;
            mem_addr <= addr_of(row, '0);
            mem_re   <= 1'b1;
            state    <= REQ;
          end else if (!last_row) begin
            plane    <= '0;
            row      <= row + 1'b1;
            mem_addr <= addr_of(row + 1'b1, '0);
            mem_re   <= 1'b1;
            state    <= REQ;
          end else begin
            frame_done <= 1'b1;
            plane      <= '0;
            row        <= '0;
            mem_addr   <= '0;
            if (enable) begin
              mem_re <= 1'b1;
              state  <= REQ;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan_reader.sv
// Self-checking bench for hub75_scan_reader on a 4x4 panel.
// Reference model derives scan order and bit planes from array arithmetic.
module tb_hub75_scan_reader;

  localparam int WIDTH   = 4;
  localparam int HEIGHT  = 4;
  localparam int CHAINED = 1;
  localparam int ADDR_W  = 12;
  localparam int ROW_W   = 5;
  localparam int BOE     = 2;
  localparam int LINE    = WIDTH * CHAINED;
  localparam int ROWS    = HEIGHT / 2;
  localparam int PL      = 4;
  localparam int PER_FR  = ROWS * PL * LINE;
`ifdef SCAN_BLANK_EN
  localparam int BLANK_EXTRA = 4 * ROWS * 4;
`else
  localparam int BLANK_EXTRA = 0;
`endif
  localparam int FRAME = ROWS * PL * (3 * LINE + 1)
                       + ROWS * BOE * 15 + BLANK_EXTRA;

  logic              clk = 0;
  logic              rst = 1;
  logic              enable = 0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [23:0]       mem_dat = '0;
  logic              r0, g0, b0, r1, g1, b1;
  logic [ROW_W-1:0]  panel_addr;
  logic              panel_clk, panel_lat, panel_oe_n;
  logic              frame_done;

  hub75_scan_reader #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BPP(12),
    .CHAINED(CHAINED), .ADDR_W(ADDR_W), .ROW_W(ROW_W),
    .BASE_OE_CYCLES(BOE)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_dat(mem_dat),
    .panel_r0(r0), .panel_g0(g0), .panel_b0(b0),
    .panel_r1(r1), .panel_g1(g1), .panel_b1(b1),
    .panel_addr(panel_addr), .panel_clk(panel_clk),
    .panel_lat(panel_lat), .panel_oe_n(panel_oe_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [23:0] mem [0:7];

  always @(posedge clk)
    if (mem_re) mem_dat <= mem[mem_addr[2:0]];

  int checks = 0;
  int errors = 0;

  // Observed event streams, sampled on the falling edge.
  int          cyc = 0;
  int          first_re = -1;
  int          run = 0;
  int          q_addr[$];
  logic [5:0]  q_col[$];
  int          q_lat[$];
  int          q_oe[$];
  int          q_fd[$];

  always @(negedge clk) begin
    if (!rst) begin
      cyc = cyc + 1;
      if (mem_re) begin
        q_addr.push_back(int'(mem_addr));
        if (first_re < 0) first_re = cyc;
      end
      if (panel_clk) q_col.push_back({r0, g0, b0, r1, g1, b1});
      if (panel_lat) q_lat.push_back(int'(panel_addr));
      if (!panel_oe_n) run = run + 1;
      else if (run != 0) begin
        q_oe.push_back(run);
        run = 0;
      end
      if (frame_done) q_fd.push_back(cyc);
    end
  end

  task automatic clear_obs;
    @(posedge clk);
    #1;
    q_addr.delete();
    q_col.delete();
    q_lat.delete();
    q_oe.delete();
    q_fd.delete();
    first_re = -1;
    run = 0;
  endtask

  task automatic fill_mem;
    for (int i = 0; i < 8; i++) mem[i] = 24'($urandom);
  endtask

  // Model: k-th column shift of a frame -> address and plane.
  function automatic int m_addr(input int k);
    int rp, r, c;
    rp = k / LINE;
    c  = k % LINE;
    r  = rp / PL;
    return r * LINE + c;
  endfunction

  function automatic int m_plane(input int k);
    return (k / LINE) % PL;
  endfunction

  function automatic logic [5:0] m_col(input logic [23:0] w, input int p);
    logic [11:0] top, bot;
    logic [3:0]  tr, tg, tb_, br, bg, bb;
    top = w[23:12];
    bot = w[11:0];
    tr = top[11:8]; tg = top[7:4]; tb_ = top[3:0];
    br = bot[11:8]; bg = bot[7:4]; bb = bot[3:0];
    return {tr[p], tg[p], tb_[p], br[p], bg[p], bb[p]};
  endfunction

  task automatic test_reset;
    bit ok;
    int n;
    int bad;
    rst = 1;
    enable = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (panel_oe_n !== 1'b1 || mem_re !== 1'b0 || panel_lat !== 1'b0 ||
        panel_clk !== 1'b0 || mem_addr !== '0 || frame_done !== 1'b0 ||
        panel_addr !== '0)
      begin
        errors++;
        $display("FAIL reset_state oe_n=%b re=%b lat=%b clk=%b addr=%0d fd=%b",
                 panel_oe_n, mem_re, panel_lat, panel_clk, mem_addr, frame_done);
      end
    rst = 0;
    enable = 1;
    ok = 0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (panel_clk) n++;
      if (n == 2) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reach_clkh got=%0d clk pulses want=2", n);
    end
    rst = 1;
    #1;
    checks++;
    if (panel_oe_n !== 1'b1 || panel_lat !== 1'b0 || panel_clk !== 1'b0 ||
        mem_re !== 1'b0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_clkh oe_n=%b lat=%b clk=%b re=%b addr=%0d want 1,0,0,0,0",
               panel_oe_n, panel_lat, panel_clk, mem_re, mem_addr);
    end
    enable = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (mem_re !== 1'b0 || panel_oe_n !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_hold bad_cycles=%0d want=0", bad);
    end
  endtask

  task automatic test_enable_drop;
    bit ok;
    fill_mem();
    mem[0] = 24'hF0A5C3;
    clear_obs();
    enable = 1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (first_re >= 0) begin ok = 1; break; end
    end
    repeat (5) @(negedge clk);
    enable = 0;
    for (int i = 0; i < 4 * FRAME && q_fd.size() == 0; i++)
      @(negedge clk);
    checks++;
    if (!ok || q_fd.size() != 1) begin
      errors++;
      $display("FAIL frame_done_seen got=%0d want=1", q_fd.size());
    end
    repeat (40) @(negedge clk);
    checks++;
    if (q_fd.size() != 1 || q_addr.size() != PER_FR) begin
      errors++;
      $display("FAIL back_to_idle fd=%0d reads=%0d want 1,%0d",
               q_fd.size(), q_addr.size(), PER_FR);
    end
  endtask

  task automatic test_scan_order;
    int bad;
    bad = 0;
    for (int k = 0; k < PER_FR; k++)
      if (k >= q_addr.size() || q_addr[k] != m_addr(k)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL scan_order bad=%0d first=%0d want=0", bad,
               (q_addr.size() > 0) ? q_addr[0] : -1);
    end
  endtask

  task automatic test_bit_planes;
    int bad;
    bad = 0;
    for (int k = 0; k < PER_FR; k++)
      if (k >= q_col.size() ||
          q_col[k] !== m_col(mem[m_addr(k)], m_plane(k))) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bit_planes bad=%0d want=0", bad);
    end
  endtask

  task automatic test_known_word;
    logic [5:0] p0, p3;
    p0 = (q_col.size() > 0)  ? q_col[0]  : 6'bx;
    p3 = (q_col.size() > 12) ? q_col[12] : 6'bx;
    checks++;
    if (p0 !== 6'b100101) begin
      errors++;
      $display("FAIL known_plane0 got=%b want=100101", p0);
    end
    checks++;
    if (p3 !== 6'b101010) begin
      errors++;
      $display("FAIL known_plane3 got=%b want=101010", p3);
    end
  endtask

  task automatic test_latch_oe;
    int bad_l, bad_o;
    bad_l = 0;
    bad_o = 0;
    checks++;
    if (q_lat.size() != ROWS * PL || q_oe.size() != ROWS * PL) begin
      errors++;
      $display("FAIL latch_count lat=%0d oe=%0d want=%0d",
               q_lat.size(), q_oe.size(), ROWS * PL);
    end
    for (int i = 0; i < ROWS * PL; i++) begin
      if (i >= q_lat.size() || q_lat[i] != i / PL) bad_l++;
      if (i >= q_oe.size() || q_oe[i] != (BOE << (i % PL))) bad_o++;
    end
    checks++;
    if (bad_l != 0) begin
      errors++;
      $display("FAIL latch_rows bad=%0d want=0", bad_l);
    end
    checks++;
    if (bad_o != 0) begin
      errors++;
      $display("FAIL oe_widths bad=%0d first=%0d want=0", bad_o,
               (q_oe.size() > 0) ? q_oe[0] : -1);
    end
  endtask

  task automatic test_frame_length;
    int len;
    len = (q_fd.size() > 0) ? q_fd[0] - first_re : -1;
    checks++;
    if (len != FRAME) begin
      errors++;
      $display("FAIL frame_length got=%0d want=%0d", len, FRAME);
    end
  endtask

  task automatic test_back_to_back;
    int bad;
    fill_mem();
    clear_obs();
    enable = 1;
    for (int i = 0; i < 3 * FRAME && q_fd.size() < 2; i++)
      @(negedge clk);
    enable = 0;
    for (int i = 0; i < 2 * FRAME && q_fd.size() < 3; i++)
      @(negedge clk);
    repeat (40) @(negedge clk);
    checks++;
    if (q_fd.size() != 3) begin
      errors++;
      $display("FAIL b2b_frames got=%0d want=3", q_fd.size());
    end else begin
      checks++;
      if (q_fd[0] - first_re != FRAME || q_fd[1] - q_fd[0] != FRAME ||
          q_fd[2] - q_fd[1] != FRAME) begin
        errors++;
        $display("FAIL b2b_period got=%0d,%0d,%0d want=%0d",
                 q_fd[0] - first_re, q_fd[1] - q_fd[0],
                 q_fd[2] - q_fd[1], FRAME);
      end
    end
    bad = 0;
    for (int k = 0; k < 3 * PER_FR; k++) begin
      if (k >= q_addr.size() || q_addr[k] != m_addr(k % PER_FR)) bad++;
      else if (k >= q_col.size() ||
               q_col[k] !== m_col(mem[q_addr[k]], m_plane(k % PER_FR)))
        bad++;
    end
    checks++;
    if (bad != 0 || q_addr.size() != 3 * PER_FR) begin
      errors++;
      $display("FAIL b2b_stream bad=%0d reads=%0d want 0,%0d",
               bad, q_addr.size(), 3 * PER_FR);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    test_reset();
    test_enable_drop();
    test_scan_order();
    test_bit_planes();
    test_known_word();
    test_latch_oe();
    test_frame_length();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hub75_scan_reader.md
Name: hub75_scan_reader

Overview:
- Read-side engine for the panel framebuffer: walks the dual-port frame memory through its read port and drives a HUB75 LED matrix.
- Uses binary-code-modulation (BCM) bit planes.
- Each memory word holds two 12-bit pixels: one from the top half-panel, one from the matching bottom-half pixel.
- Sits between the framebuffer read port and the panel connector pins.

Parameters:
- WIDTH, 96, panel width in pixels
- HEIGHT, 48, panel height in pixels; scan rows = HEIGHT/2
- BPP, 12, bits per pixel (4 per colour); bit planes = BPP/3 = 4
- CHAINED, 1, number of panels chained horizontally
- ADDR_W, 12, framebuffer address width
- ROW_W, 5, panel row-address width (must satisfy 2^ROW_W >= HEIGHT/2)
- BASE_OE_CYCLES, 64, display time of plane 0 in clk cycles; plane p displays BASE_OE_CYCLES<<p

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  start/continue scanning frames
- mem_addr  out  ADDR_W  framebuffer read address
- mem_re  out  1  framebuffer read enable
- mem_dat  in  24  read data, valid the cycle after mem_re
- panel_r0, panel_g0, panel_b0  out  1 each  top-half colour bits
- panel_r1, panel_g1, panel_b1  out  1 each  bottom-half colour bits
- panel_addr  out  ROW_W  panel row select
- panel_clk  out  1  shift clock
- panel_lat  out  1  latch strobe
- panel_oe_n  out  1  output enable, active low
- frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0 except panel_oe_n=1; row, column and plane counters cleared.
- Word layout: mem_dat[23:12] = top pixel {R[3:0],G[3:0],B[3:0]}; mem_dat[11:0] = bottom pixel, same order.
- Plane p bit mapping: r0=dat[20+p], g0=dat[16+p], b0=dat[12+p], r1=dat[8+p], g1=dat[4+p], b1=dat[p].
- Address: mem_addr = row*(CHAINED*WIDTH) + col; col 0..CHAINED*WIDTH-1; row 0..HEIGHT/2-1.
- Scan order: per row, planes 0..3 in ascending order; then next row.
- FSM states:
  - IDLE: if enable=1, go to REQ with row=col=plane=0.
  - REQ: mem_re=1, mem_addr driven; panel_clk=0.
  - DATA: capture mem_dat, drive the six colour bits; panel_clk=0.
  - CLKH: panel_clk=1, colour bits held.
    - If col is not last: col+1, go to REQ.
    - Otherwise: col=0, go to LATCH.
  - LATCH: one cycle; panel_lat=1, panel_oe_n=1, panel_addr<=row.
  - DISPLAY: panel_oe_n=0 for exactly BASE_OE_CYCLES<<plane cycles.
    - If plane<3: plane+1, go to REQ.
    - Else if row not last: plane=0, row+1, go to REQ.
    - Else (last row, plane 3): pulse frame_done; row=0, plane=0; go to REQ if enable=1, else IDLE.
- Timing:
  - 3 cycles per column, so one row-plane shift = 3*CHAINED*WIDTH cycles.
  - panel_oe_n is 1 in every state except DISPLAY.
  - mem_re is asserted only in REQ.
- enable is sampled only at IDLE and at frame end; deassertion mid-frame completes the frame.
- The memory's read-first/write collision behaviour is not this block's concern; any write landing mid-frame may tear and is acceptable.
- Plane-count width: BPP/3 planes. The display counter is wide enough for BASE_OE_CYCLES<<3 with no overflow.

Optional Feature:
- Macro: SCAN_BLANK_EN.
- Defined: adds a BLANK state after LATCH lasting BLANK_CYCLES (localparam, 4) with panel_oe_n=1, so the row address settles before display to suppress ghosting.
- Undefined: LATCH goes directly to DISPLAY.
- Frame length differs by 4*(HEIGHT/2)*BLANK_CYCLES cycles between the two builds.

Decomposition:
- Shared package hub75_pkg holds:
  - state enum (IDLE, REQ, DATA, CLKH, LATCH, BLANK, DISPLAY)
  - PLANES=BPP/3
  - word bit-offset constants (R_TOP=20, G_TOP=16, B_TOP=12, R_BOT=8, G_BOT=4, B_BOT=0)
- One sub-module, bcm_timer: loads BASE_OE_CYCLES<<plane, counts down, asserts done. It is reusable for the blank guard.

Test Plan (WIDTH=4, HEIGHT=4, CHAINED=1, BASE_OE_CYCLES=2, stub memory with 1-cycle read latency):
- rst=1 mid-CLKH -> same cycle: panel_oe_n=1, panel_lat=0, panel_clk=0, mem_re=0, mem_addr=0; after release with enable=0, stays IDLE.
- enable=1 -> mem_addr on successive REQ cycles: 0,1,2,3 four times (planes 0..3), then 4,5,6,7 four times; panel_addr=0 then 1 at LATCH.
- Word 24'hF0A5C3 at addr 0:
  - plane 0 -> r0,g0,b0,r1,g1,b1 = 1,0,0,1,0,1
  - plane 3 -> 1,0,1,0,1,0
  - both sampled at CLKH rising edge.
- DISPLAY panel_oe_n low widths for planes 0..3 = 2,4,8,16 cycles; exactly one panel_lat pulse before each.
- enable dropped during row 0 -> frame completes, frame_done pulses once after row 1 plane 3, FSM returns to IDLE; frame length = 8*(12+1)+2*30 = 164 cycles (plus 32 with SCAN_BLANK_EN).
